// File: rtl/program_runner.sv
// program_runner: host-side job sequencer wrapped around the processor core.
// It preloads a window of data memory from a byte stream, pulses the core's
// start input, times the run until the core raises done (or a timeout
// expires), then streams a result window of data memory back out.
// Outside RUN it owns the data-memory port; mem_sel_o tells the top level
// which side to route onto the memory.
`timescale 1ns/1ps

module program_runner #(
  parameter int ADDR_W       = 8,
  parameter int LOAD_BASE    = 0,
  parameter int LOAD_LEN     = 64,
  parameter int DUMP_BASE    = 64,
  parameter int DUMP_LEN     = 64,
  parameter int START_CYCLES = 2,
  parameter int MAX_CYCLES   = 65535
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              go_i,
  // load stream
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_data_i,
  // dump stream
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [7:0]        out_data_o,
  // core handshake
  output logic              core_start_o,
  input  logic              core_done_i,
  // data-memory port
  output logic              mem_sel_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  // status
  output logic              busy_o,
  output logic              error_o,
  output logic [15:0]       cycle_count_o
);

  // One spare bit so a window covering the whole memory still has a
  // representable last index.
  localparam int IDX_W = ADDR_W + 1;
  localparam int SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LOAD_LAST   = IDX_W'((LOAD_LEN > 0) ? LOAD_LEN - 1 : 0);
  localparam logic [IDX_W-1:0]  DUMP_LAST   = IDX_W'((DUMP_LEN > 0) ? DUMP_LEN - 1 : 0);
  localparam logic [SC_W-1:0]   START_LAST  = SC_W'((START_CYCLES > 0) ? START_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] DUMP_BASE_A = ADDR_W'(DUMP_BASE);
  localparam logic [15:0]       MAX_C       = 16'(MAX_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DUMP  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SC_W-1:0]  start_cnt_q, start_cnt_d;
  logic [15:0]      cycle_q, cycle_d;
  logic             error_q, error_d;

  // Saturating increment of the run timer; it never wraps past MAX_C.
  logic [15:0] cycle_inc;
  assign cycle_inc = (cycle_q >= MAX_C) ? MAX_C : cycle_q + 16'd1;

  // Low address bits of the shared window index.
  logic [ADDR_W-1:0] idx_addr;
  assign idx_addr = idx_q[ADDR_W-1:0];

  // State and bookkeeping registers; reset takes effect immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      start_cnt_q <= '0;
      cycle_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_cnt_q <= start_cnt_d;
      cycle_q     <= cycle_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic: job sequencing, window index, start and run timers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    start_cnt_d = start_cnt_q;
    cycle_d     = cycle_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          error_d     = 1'b0;
          idx_d       = '0;
          start_cnt_d = '0;
          state_d     = (LOAD_LEN == 0) ? ST_START : ST_LOAD;
        end
      end

      ST_LOAD: begin
        // in_ready is high throughout LOAD, so in_valid alone marks a transfer.
        if (in_valid_i) begin
          if (idx_q == LOAD_LAST) begin
            idx_d       = '0;
            start_cnt_d = '0;
            state_d     = ST_START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_START: begin
        // core_done is deliberately not looked at here: the core may still
        // report the previous job's done while it is being restarted.
        if (start_cnt_q == START_LAST) begin
          cycle_d = '0;
          state_d = ST_RUN;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // The cycle that samples done is itself counted as a run cycle.
        cycle_d = cycle_inc;
        if (core_done_i) begin
          idx_d   = '0;
          state_d = (DUMP_LEN == 0) ? ST_IDLE : ST_DUMP;
        end else if (cycle_inc == MAX_C) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DUMP: begin
        if (out_ready_i) begin
          if (idx_q == DUMP_LAST) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: handshakes and port ownership follow the registered
  // state; only the LOAD write strobe/data pass in_valid/in_data through.
  always_comb begin
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    out_data_o   = 8'h00;
    core_start_o = 1'b0;
    mem_sel_o    = 1'b1;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = 8'h00;
    busy_o       = (state_q != ST_IDLE);

    case (state_q)
      ST_LOAD: begin
        in_ready_o  = 1'b1;
        mem_addr_o  = LOAD_BASE_A + idx_addr;
        mem_write_o = in_valid_i;
        mem_wdata_o = in_valid_i ? in_data_i : 8'h00;
      end

      ST_START: begin
        core_start_o = 1'b1;
      end

      ST_RUN: begin
        mem_sel_o = 1'b0;
      end

      ST_DUMP: begin
        // The address only moves on a transfer, so the combinational read
        // data stays put while the consumer stalls.
        out_valid_o = 1'b1;
        mem_addr_o  = DUMP_BASE_A + idx_addr;
        out_data_o  = mem_rdata_i;
      end

      default: begin
      end
    endcase
  end

  assign error_o       = error_q;
  assign cycle_count_o = cycle_q;

endmodule
